// File: rtl/norm_pkg.sv
// -----------------------------------------------------------------------------
// norm_pkg
//
// Purpose:
//   Shared definitions for the seq_normalizer block:
//     - norm_state_t : FSM state encoding (IDLE, SHIFT, DONE)
//     - NORM_WIDTH_DEF : default data width
//     - amt_width()  : width of the shift-amount field for a given data width
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package norm_pkg;

    // Default data width of the normalizer datapath.
    localparam int NORM_WIDTH_DEF = 8;

    // FSM states. The encoding is exported on the debug state port of the top
    // level, so it is kept explicit and stable.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } norm_state_t;

    // Number of bits needed to hold a shift amount of 0 .. w-1.
    // A one-bit minimum keeps degenerate widths legal.
    function automatic int amt_width(input int w);
        int r;
        r = $clog2(w);
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage : norm_pkg

// File: rtl/bit_reverse_n.sv
// -----------------------------------------------------------------------------
// bit_reverse_n
//
// Purpose:
//   Purely combinational bit-order reversal: q_o[i] = d_i[WIDTH-1-i].
//   Used by seq_normalizer to turn a right-normalize request into a
//   left-normalize on the working register, and to turn the result back.
//
// Parameters:
//   WIDTH  data width
//
// Ports:
//   d_i  input  [WIDTH-1:0]  word to reverse
//   q_o  output [WIDTH-1:0]  bit-reversed word
// -----------------------------------------------------------------------------
module bit_reverse_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign q_o[i] = d_i[WIDTH-1-i];
    end

endmodule : bit_reverse_n

// File: rtl/seq_normalizer.sv
// -----------------------------------------------------------------------------
// seq_normalizer
//
// Purpose:
//   Leading-zero normalizer. Accepts a word and a direction, returns the word
//   shifted so that its first set bit (counting from the chosen end) lands on
//   that end, together with the number of positions shifted and a flag for an
//   all-zero input. Direction: 0 = toward MSB (left), 1 = toward LSB (right).
//
//   A right-normalize is performed as a left-normalize on the bit-reversed
//   word; the result is reversed back when it is registered for output.
//
// Configuration macro:
//   NORM_FAST_EN  defined   : SHIFT resolves in a single cycle using a
//                             combinational leading-zero count and one barrel
//                             shift. Latency is 1 cycle for every input.
//                 undefined : iterative one-bit-per-cycle shift (default).
//                             Latency is k+1 cycles for k leading zeros.
//   Both builds produce identical y_out / amt_out / zero_out.
//
// Handshake (both ports):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. in_ready is high exactly in IDLE; out_valid is high exactly in DONE.
//   While out_valid is high and out_ready is low, every output holds. After an
//   output transfer the block returns to IDLE; in_ready rises the cycle after,
//   never in the same cycle as the output transfer.
//
// Parameters:
//   WIDTH  data width (>= 2)
//   AMT_W  width of amt_out
//
// Ports:
//   clk        input         rising-edge clock
//   reset_n    input         asynchronous active-low reset
//   in_valid   input         input word offered
//   in_ready   output        block can accept (IDLE)
//   a_in       input  WIDTH  word to normalize
//   dir_in     input         0 = left, 1 = right
//   out_valid  output        result valid (DONE)
//   out_ready  input         consumer accepts result
//   y_out      output WIDTH  normalized word
//   amt_out    output AMT_W  positions shifted
//   zero_out   output        input was all zeros
//   state_dbg  output 2      current FSM state (norm_state_t encoding)
// -----------------------------------------------------------------------------
module seq_normalizer
    import norm_pkg::*;
#(
    parameter int WIDTH = NORM_WIDTH_DEF,
    parameter int AMT_W = amt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic             dir_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y_out,
    output logic [AMT_W-1:0] amt_out,
    output logic             zero_out,
    output logic [1:0]       state_dbg
);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    norm_state_t      state_q;
    logic [WIDTH-1:0] work_q;   // working word, always normalized toward MSB
    logic             dir_q;    // direction latched at accept
    logic [AMT_W-1:0] amt_q;    // positions shifted so far / final count
    logic             zero_q;   // accepted word was all zeros
    logic [WIDTH-1:0] y_q;      // registered result in the caller's bit order

    // -------------------------------------------------------------------------
    // Input capture: reverse the word for right-normalize requests so the
    // working register only ever shifts left.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] a_rev;
    logic [WIDTH-1:0] work_d;
    logic             zero_d;

    bit_reverse_n #(.WIDTH(WIDTH)) u_rev_in (
        .d_i (a_in),
        .q_o (a_rev)
    );

    assign work_d = dir_in ? a_rev : a_in;
    assign zero_d = (a_in == '0);

    // -------------------------------------------------------------------------
    // Final normalized word (MSB-aligned) and shift count as seen at the end
    // of SHIFT.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] fin_d;
    logic [AMT_W-1:0] amt_d;

`ifdef NORM_FAST_EN
    // Leading-zero count of a nonzero word. The highest set bit wins because
    // the scan runs upward and later hits overwrite earlier ones. An all-zero
    // word returns 0; that case never reaches this path.
    function automatic logic [AMT_W-1:0] lzc(input logic [WIDTH-1:0] v);
        logic [AMT_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                n = AMT_W'(WIDTH - 1 - i);
            end
        end
        return n;
    endfunction

    assign amt_d = lzc(work_q);
    assign fin_d = work_q << amt_d;
`else
    // Iterative build: SHIFT exits only once work_q already has its MSB set,
    // so the working register and counter are the final values.
    assign amt_d = amt_q;
    assign fin_d = work_q;
`endif

    // -------------------------------------------------------------------------
    // Output drive: restore the caller's bit order for right-normalize.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] fin_rev;
    logic [WIDTH-1:0] y_d;

    bit_reverse_n #(.WIDTH(WIDTH)) u_rev_out (
        .d_i (fin_d),
        .q_o (fin_rev)
    );

    assign y_d = dir_q ? fin_rev : fin_d;

    // -------------------------------------------------------------------------
    // FSM and datapath
    //
    // An all-zero word still spends one cycle in SHIFT so that every input,
    // including zero, reaches DONE one or more cycles after the accepting
    // edge; zero_q short-circuits the shift loop there.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            dir_q   <= 1'b0;
            amt_q   <= '0;
            zero_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_q  <= work_d;
                        dir_q   <= dir_in;
                        amt_q   <= '0;
                        zero_q  <= zero_d;
                        state_q <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (zero_q) begin
                        y_q     <= '0;
                        amt_q   <= '0;
                        state_q <= ST_DONE;
`ifdef NORM_FAST_EN
                    end else begin
                        y_q     <= y_d;
                        amt_q   <= amt_d;
                        state_q <= ST_DONE;
                    end
`else
                    end else if (work_q[WIDTH-1]) begin
                        y_q     <= y_d;
                        amt_q   <= amt_d;
                        state_q <= ST_DONE;
                    end else begin
                        // A nonzero word has a set bit, so amt_q stops at
                        // WIDTH-1 at most and never wraps.
                        work_q <= {work_q[WIDTH-2:0], 1'b0};
                        amt_q  <= amt_q + AMT_W'(1);
                    end
`endif
                end

                ST_DONE: begin
                    // Everything but state holds here, so outputs stay
                    // stable for as long as the consumer stalls.
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all come straight from registers; handshake flags decode from
    // the state register only.
    // -------------------------------------------------------------------------
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign y_out     = y_q;
    assign amt_out   = amt_q;
    assign zero_out  = zero_q;
    assign state_dbg = state_q;

endmodule : seq_normalizer
